// File: rtl/rr_queue_scheduler.sv
// rr_queue_scheduler: round-robin drain scheduler for NUM_Q queues with
// registered data_out. Each transaction runs IDLE -> READ -> CAPTURE -> OUTPUT.
// Optional build macro SCHED_FIXED_PRIO_EN: when defined, the lowest-index
// requesting queue always wins and last_grant is left untouched.
module rr_queue_scheduler #(
  parameter int NUM_Q = 4,
  parameter int WIDTH = 8,
  localparam int QID_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_Q-1:0]       q_empty,
  input  logic [NUM_Q-1:0]       q_en,
  input  logic [NUM_Q*WIDTH-1:0] q_data,
  output logic [NUM_Q-1:0]       q_rd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [QID_W-1:0]       out_qid,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, READ, CAPTURE, OUTPUT} state_t;

  state_t             state_reg, state_next;
  logic [QID_W-1:0]   grant_reg, grant_next;
  logic [QID_W-1:0]   last_grant_reg, last_grant_next;
  logic               out_valid_reg, out_valid_next;
  logic [WIDTH-1:0]   out_data_reg, out_data_next;
  logic [QID_W-1:0]   out_qid_reg, out_qid_next;

  logic [NUM_Q-1:0]   req;
  logic [QID_W-1:0]   pick;
  logic               pick_found;
  logic [WIDTH-1:0]   q_word [NUM_Q];

  // Index that is 'step' positions above 'base', wrapping at NUM_Q-1.
  function automatic logic [QID_W-1:0] rr_index(input logic [QID_W-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NUM_Q) sum = sum - NUM_Q;
    return QID_W'(sum);
  endfunction

  // Per-queue word slicing and one-hot read strobe (only in READ).
  for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_queue
    assign q_word[gi] = q_data[gi*WIDTH +: WIDTH];
    assign q_rd[gi]   = (state_reg == READ) && (grant_reg == QID_W'(gi));
  end

  // Arbitration: pick the winning queue among current requests.
  always_comb begin
    req        = ~q_empty & q_en;
    pick_found = |req;
    pick       = '0;
`ifdef SCHED_FIXED_PRIO_EN
    for (int i = NUM_Q - 1; i >= 0; i--) begin
      if (req[QID_W'(i)]) pick = QID_W'(i);
    end
`else
    for (int k = NUM_Q; k >= 1; k--) begin
      if (req[rr_index(last_grant_reg, k)]) pick = rr_index(last_grant_reg, k);
    end
`endif
  end

  // Next-state and datapath updates for the four-phase transaction.
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    out_qid_next    = out_qid_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_next = pick;
`ifndef SCHED_FIXED_PRIO_EN
          last_grant_next = pick;
`endif
          state_next = READ;
        end
      end
      READ: begin
        state_next = CAPTURE;
      end
      CAPTURE: begin
        out_data_next  = q_word[grant_reg];
        out_qid_next   = grant_reg;
        out_valid_next = 1'b1;
        state_next     = OUTPUT;
      end
      OUTPUT: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= QID_W'(NUM_Q - 1);
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_qid_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
      out_qid_reg    <= out_qid_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_qid   = out_qid_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_rr_queue_scheduler.sv
// Bench for rr_queue_scheduler: models the queues and a transaction-level
// expectation of the scheduler, comparing every cycle, plus literal scenarios.
module tb_rr_queue_scheduler;

  localparam int NQ = 4;
  localparam int W  = 8;

  logic            clk;
  logic            reset;
  logic [NQ-1:0]   q_empty;
  logic [NQ-1:0]   q_en;
  logic [NQ*W-1:0] q_data;
  logic [NQ-1:0]   q_rd;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [1:0]      out_qid;
  logic            busy;

  rr_queue_scheduler #(.NUM_Q(NQ), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .q_empty(q_empty), .q_en(q_en), .q_data(q_data),
    .q_rd(q_rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_qid(out_qid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue environment: circular storage plus a registered data_out per queue.
  logic [W-1:0] qmem [NQ][256];
  int           head [NQ];
  int           tail [NQ];
  logic [W-1:0] dout [NQ];
  int           rd_count [NQ];

  always_comb begin
    q_data  = '0;
    q_empty = '0;
    for (int i = 0; i < NQ; i++) begin
      q_data[i*W +: W] = dout[i];
      q_empty[i]       = (tail[i] == head[i]);
    end
  end

  // Transaction-level expectation: age = cycles since the grant (-1 = idle).
  int           m_age;
  int           m_grant;
  int           m_last;
  logic [W-1:0] m_word;

  int hs_qid[$];
  int hs_data[$];
  int hs_cyc[$];
  int cyc;
  int checks;
  int errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int q, input logic [W-1:0] d);
    qmem[q][tail[q] % 256] = d;
    tail[q]++;
  endtask

  function automatic int model_pick(input logic [NQ-1:0] req);
    int p;
    p = -1;
`ifdef SCHED_FIXED_PRIO_EN
    for (int i = NQ - 1; i >= 0; i--) if (req[i]) p = i;
`else
    for (int k = 1; k <= NQ; k++) begin
      if (p < 0 && req[(m_last + k) % NQ]) p = (m_last + k) % NQ;
    end
`endif
    return p;
  endfunction

  // One clock: compare outputs with the model, advance model and queues.
  task automatic cycle();
    logic [NQ-1:0] rd_s;
    logic          rst_s;
    int            p;
    @(negedge clk);
    chk("busy", {31'd0, busy}, {31'd0, m_age >= 0});
    chk("q_rd", {28'd0, q_rd}, (m_age == 0) ? (32'd1 << m_grant) : 32'd0);
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_age >= 2});
    if (m_age >= 2) begin
      chk("out_data", {24'd0, out_data}, {24'd0, m_word});
      chk("out_qid", {30'd0, out_qid}, m_grant);
    end
    rd_s  = q_rd;
    rst_s = reset;
    if (reset) begin
      m_age  = -1;
      m_last = NQ - 1;
    end else if (m_age < 0) begin
      p = model_pick(~q_empty & q_en);
      if (p >= 0) begin
        m_grant = p;
`ifndef SCHED_FIXED_PRIO_EN
        m_last = p;
`endif
        m_word = qmem[p][head[p] % 256];
        m_age  = 0;
      end
    end else if (m_age < 2) begin
      m_age++;
    end else if (out_ready) begin
      hs_qid.push_back(m_grant);
      hs_data.push_back(int'(m_word));
      hs_cyc.push_back(cyc);
      m_age = -1;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NQ; i++) begin
      if (rst_s) begin
        head[i] = tail[i];
        dout[i] = '0;
      end else if (rd_s[i]) begin
        rd_count[i]++;
        if (tail[i] != head[i]) begin
          dout[i] = qmem[i][head[i] % 256];
          head[i]++;
        end
      end
    end
  endtask

  task automatic run_hs(input int n, input int budget, input string name);
    int target;
    int c;
    target = hs_qid.size() + n;
    c = 0;
    while (hs_qid.size() < target && c < budget) begin
      cycle();
      c++;
    end
    if (hs_qid.size() < target) chk({name, "_timeout"}, hs_qid.size(), target);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    q_en = 4'hF;
    out_ready = 1'b1;
    while ((q_empty != 4'hF || m_age >= 0) && c < budget) begin
      cycle();
      c++;
    end
    chk("drain_timeout", {28'd0, q_empty}, 32'hF);
  endtask

  int base;
  int rd0;
  int rd2;
  int n;

  initial begin
    checks = 0; errors = 0; cyc = 0;
    m_age = -1; m_last = NQ - 1; m_grant = 0; m_word = '0;
    for (int i = 0; i < NQ; i++) begin
      head[i] = 0; tail[i] = 0; dout[i] = '0; rd_count[i] = 0;
    end
    reset = 1'b1; q_en = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_q_rd", {28'd0, q_rd}, 32'd0);
    chk("reset_out_data", {24'd0, out_data}, 32'd0);
    chk("reset_out_qid", {30'd0, out_qid}, 32'd0);

`ifndef SCHED_FIXED_PRIO_EN
    // Scenario 1: round-robin over two words per queue, ready held high.
    for (int i = 0; i < NQ; i++) begin
      push(i, 8'h10 + 8'(i));
      push(i, 8'h20 + 8'(i));
    end
    q_en = 4'hF; out_ready = 1'b1;
    base = hs_qid.size();
    run_hs(8, 100, "s1");
    if (hs_qid.size() >= base + 8) begin
      for (int k = 0; k < 8; k++) begin
        chk("s1_qid", hs_qid[base + k], k % 4);
        chk("s1_data", hs_data[base + k], (k < 4) ? (32'h10 + k) : (32'h20 + k - 4));
        if (k > 0) chk("s1_spacing", hs_cyc[base + k] - hs_cyc[base + k - 1], 4);
      end
    end
    drain(50);

    // Scenario 2: single queue, consumer stalls for 10 cycles.
    out_ready = 1'b0;
    rd2 = rd_count[2];
    push(2, 8'hA5);
    n = 0;
    while (m_age < 2 && n < 20) begin cycle(); n++; end
    chk("s2_valid_reached", {31'd0, out_valid}, 32'd1);
    repeat (10) cycle();
    out_ready = 1'b1;
    base = hs_qid.size();
    run_hs(1, 10, "s2");
    repeat (5) cycle();
    chk("s2_rd_pulses", rd_count[2] - rd2, 1);
    if (hs_qid.size() > base) begin
      chk("s2_qid", hs_qid[base], 2);
      chk("s2_data", hs_data[base], 32'hA5);
    end
    chk("s2_idle", {31'd0, busy}, 32'd0);

    // Scenario 3: only queues 1 and 3 enabled.
    do_reset(1);
    for (int i = 0; i < NQ; i++) repeat (4) push(i, 8'($urandom));
    q_en = 4'b1010;
    rd0 = rd_count[0]; rd2 = rd_count[2];
    base = hs_qid.size();
    run_hs(4, 60, "s3");
    if (hs_qid.size() >= base + 4) begin
      for (int k = 0; k < 4; k++) chk("s3_qid", hs_qid[base + k], (k % 2 == 0) ? 1 : 3);
    end
    chk("s3_rd0_unused", rd_count[0] - rd0, 0);
    chk("s3_rd2_unused", rd_count[2] - rd2, 0);

    // Scenario 4: reset during CAPTURE, after queue 2 was granted.
    q_en = 4'b0100;
    push(2, 8'h5A);
    n = 0;
    while (m_age != 1 && n < 30) begin cycle(); n++; end
    chk("s4_in_capture", m_age, 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("s4_out_valid", {31'd0, out_valid}, 32'd0);
    chk("s4_q_rd", {28'd0, q_rd}, 32'd0);
    chk("s4_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < NQ; i++) push(i, 8'h40 + 8'(i));
    q_en = 4'hF; out_ready = 1'b1;
    base = hs_qid.size();
    run_hs(1, 20, "s4");
    if (hs_qid.size() > base) chk("s4_first_qid", hs_qid[base], 0);
    drain(60);
`else
    // Fixed priority: queue 0 words precede any queue 3 word.
    for (int k = 0; k < 3; k++) begin
      push(0, 8'h60 + 8'(k));
      push(3, 8'h70 + 8'(k));
    end
    q_en = 4'hF; out_ready = 1'b1;
    base = hs_qid.size();
    run_hs(6, 80, "s6");
    if (hs_qid.size() >= base + 6) begin
      for (int k = 0; k < 6; k++) begin
        chk("s6_qid", hs_qid[base + k], (k < 3) ? 0 : 3);
        chk("s6_data", hs_data[base + k], (k < 3) ? (32'h60 + k) : (32'h70 + k - 3));
      end
    end
    drain(60);
`endif

    // Scenario 5: idle for 20 cycles, then one word into queue 3.
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (busy !== 1'b0 || q_rd !== '0) chk("s5_idle", {27'd0, busy, q_rd}, 32'd0);
    end
    push(3, 8'h3C);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin cycle(); n++; end
    chk("s5_latency", n, 3);
    chk("s5_qid", {30'd0, out_qid}, 32'd3);
    chk("s5_data", {24'd0, out_data}, 32'h3C);
    run_hs(1, 10, "s5");

    // Randomised traffic with changing enables and back-pressure.
    do_reset(1);
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(15) == 0) q_en = 4'($urandom);
      out_ready = ($urandom_range(9) < 7);
      if ($urandom_range(2) == 0) begin
        n = $urandom_range(NQ - 1);
        if (tail[n] - head[n] < 8) push(n, 8'($urandom));
      end
      if ($urandom_range(499) == 0) reset = 1'b1;
      cycle();
      reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_queue_scheduler.md
Name: rr_queue_scheduler

Overview:
Round-robin drain scheduler for a bank of NUM_Q independent queue instances. Each queue has registered data_out, a one-cycle rd strobe, and an empty flag.
- Picks a non-empty, enabled queue and pulses its rd for one cycle.
- Captures the word on the cycle after the read.
- Presents the word to a single downstream consumer through a valid/ready handshake.
- The scheduler is the only reader of these queues.

Parameters:
NUM_Q, 4, number of queues served (2..16).
WIDTH, 8, data width of each queue.
QID_W (localparam), ceil(log2(NUM_Q)) with a minimum of 1, width of the queue-index output.

Ports:
clk  in  1  clock, all logic on rising edge.
reset  in  1  synchronous, active-high.
q_empty  in  NUM_Q  empty flag of each queue; bit i belongs to queue i.
q_en  in  NUM_Q  per-queue service enable; a 0 bit excludes that queue from arbitration.
q_data  in  NUM_Q*WIDTH  data_out of each queue; queue i occupies bits [i*WIDTH +: WIDTH].
q_rd  out  NUM_Q  read strobe to each queue; at most one bit high at a time.
out_valid  out  1  out_data/out_qid hold a word.
out_ready  in  1  consumer accepts the word when out_valid&&out_ready.
out_data  out  WIDTH  captured word.
out_qid  out  QID_W  index of the source queue of out_data.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (any cycle, including mid-transaction):
  - state=IDLE; q_rd=0; out_valid=0; out_data=0; out_qid=0; busy=0.
  - last_grant=NUM_Q-1, so queue 0 has first priority after reset.
  - A read already issued to a queue before reset is dropped; the queue's own reset is applied concurrently by the system.
- Request vector: req = ~q_empty & q_en. It is evaluated only in IDLE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise register grant = the first set bit of req, searching upward from last_grant+1 and wrapping at NUM_Q-1 to 0.
  - Set last_grant=grant and go to READ.
- READ (1 cycle): q_rd[grant]=1, all other q_rd bits 0. The queue updates data_out at the closing edge. Go to CAPTURE.
- CAPTURE (1 cycle): out_data<=q_data[grant], out_qid<=grant, out_valid<=1 at the closing edge. Go to OUTPUT.
- OUTPUT:
  - out_valid=1; out_data and out_qid are held stable while out_ready=0, with no timeout.
  - On out_valid&&out_ready, clear out_valid at that edge and return to IDLE.
- Latency: the IDLE cycle that sees a request is followed by READ, then CAPTURE, then out_valid high. out_valid rises exactly 3 edges after the first IDLE cycle with req!=0.
- Throughput: 1 word per 4 cycles when out_ready is held high.
- q_rd is never asserted to a queue whose empty flag was 1 in the arbitration cycle. Because the scheduler is the only reader, the queue cannot empty between IDLE and READ.
- Changes to q_en or q_empty after arbitration do not affect an in-flight transaction. They take effect at the next IDLE.
- Fairness: with all queues continuously non-empty and enabled, grants cycle 0,1,...,NUM_Q-1,0,...
- A queue whose q_en is cleared is skipped. last_grant still advances only to the queue actually granted.
- Writes into the queues are outside this block and may coincide with any state.

Optional Feature:
Macro SCHED_FIXED_PRIO_EN.
- Defined: strict fixed priority. The lowest-index set bit of req always wins; last_grant is unused and not updated.
- Undefined (default): round-robin as above.
- Ports, FSM and latency are identical in both builds.

Test Plan:
1. Reset, then queues 0..3 each preloaded with 2 words (0x10+i, 0x20+i), q_en=4'hF, out_ready=1 -> output order qid 0,1,2,3,0,1,2,3 with data 0x10,0x11,0x12,0x13,0x20,0x21,0x22,0x23. out_valid high every 4th cycle.
2. Only queue 2 non-empty (0xA5), out_ready=0 for 10 cycles, then 1 -> single q_rd[2] pulse; out_data=0xA5 and out_qid=2 held for all 10 cycles; no further q_rd; return to IDLE.
3. All queues non-empty, q_en=4'b1010 -> grants alternate 1,3,1,3; q_rd[0] and q_rd[2] never asserted.
4. Assert reset for 1 cycle while in CAPTURE -> next cycle out_valid=0, q_rd=0, busy=0; first grant after reset goes to queue 0.
5. All queues empty for 20 cycles -> q_rd=0 and busy=0 throughout. Write 0x3C into queue 3 -> q_rd[3] pulse, then out_valid 3 edges after the empty flag falls.
6. Build with SCHED_FIXED_PRIO_EN, queues 0 and 3 each hold 3 words -> all three queue-0 words are delivered before any queue-3 word.
